// File: rtl/pc_pkg.sv
// Shared types and helpers for the program counter and its return stack.
package pc_pkg;

    typedef enum logic [2:0] {
        PC_OP_HOLD = 3'd0,
        PC_OP_INC  = 3'd1,
        PC_OP_LOAD = 3'd2,
        PC_OP_CALL = 3'd3,
        PC_OP_RET  = 3'd4,
        PC_OP_REL  = 3'd5
    } pc_op_e;

    // Ceiling log2: number of bits needed to index n distinct values.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// LIFO of return addresses; reset clears the occupancy count only.
module pc_ret_stack
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned SPW   = clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [SPW-1:0]   sp,
    output logic             full,
    output logic             empty
);

    localparam int unsigned IDXW    = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam int unsigned ENTRIES = 1 << IDXW;

    logic [WIDTH-1:0] mem [ENTRIES];

    assign full  = (sp == SPW'(DEPTH));
    assign empty = (sp == '0);
    assign dout  = empty ? '0 : mem[IDXW'(sp - 1'b1)];

    // Caller guarantees push only when not full and pop only when not empty.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sp <= '0;
        end else if (push) begin
            mem[IDXW'(sp)] <= din;
            sp             <= sp + 1'b1;
        end else if (pop) begin
            sp <= sp - 1'b1;
        end
    end

endmodule

// File: rtl/program_counter_stack.sv
// Program counter with call/return stack, wrap pulse and sticky fault.
// Optional relative branch input enabled by defining PC_BRANCH_REL_EN.
module program_counter_stack
    import pc_pkg::*;
#(
    parameter int unsigned     WIDTH     = 4,
    parameter int unsigned     DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int unsigned     SPW       = clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             en,
    input  logic             load,
    input  logic             call,
    input  logic             ret,
`ifdef PC_BRANCH_REL_EN
    input  logic             rel,
`endif
    input  logic             OE,
    input  logic [WIDTH-1:0] PC_in,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] PC_out,
    output logic             on,
    output logic [SPW-1:0]   sp,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             wrap,
    output logic             fault
);

    pc_op_e           op_c;
    logic             fault_set_c;
    logic [WIDTH-1:0] top_c;
    logic [WIDTH-1:0] count_inc_c;

    assign count_inc_c = count + WIDTH'(1);
    assign PC_out      = OE ? count : '0;
    assign on          = en & ~fault;

    // One operation per cycle; stack misuse raises fault instead of executing.
    always_comb begin
        op_c        = PC_OP_HOLD;
        fault_set_c = 1'b0;
        if (fault) begin
            op_c = PC_OP_HOLD;
        end else if (ret) begin
            if (stack_empty) fault_set_c = 1'b1;
            else             op_c        = PC_OP_RET;
        end else if (call) begin
            if (stack_full) fault_set_c = 1'b1;
            else            op_c        = PC_OP_CALL;
        end else if (load) begin
            op_c = PC_OP_LOAD;
`ifdef PC_BRANCH_REL_EN
        end else if (rel) begin
            op_c = PC_OP_REL;
`endif
        end else if (en) begin
            op_c = PC_OP_INC;
        end
    end

    pc_ret_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .SPW   (SPW)
    ) u_stack (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (op_c == PC_OP_CALL),
        .pop   (op_c == PC_OP_RET),
        .din   (count_inc_c),
        .dout  (top_c),
        .sp    (sp),
        .full  (stack_full),
        .empty (stack_empty)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            count <= RESET_VEC;
            wrap  <= 1'b0;
            fault <= 1'b0;
        end else begin
            wrap <= (op_c == PC_OP_INC) && (count == '1);
            if (fault_set_c) fault <= 1'b1;
            case (op_c)
                PC_OP_INC:  count <= count_inc_c;
                PC_OP_LOAD: count <= PC_in;
                PC_OP_CALL: count <= PC_in;
                PC_OP_RET:  count <= top_c;
                // Two's-complement add is the same bit operation as unsigned mod 2^WIDTH.
                PC_OP_REL:  count <= count + PC_in;
                default:    count <= count;
            endcase
        end
    end

endmodule
